p2s_feed_scheduler: RTL

Schedules loads of demapped soft-bit words into the parallel-to-serial converter of the DeFEC chain. Buffers words with their modulation order in a small FIFO and issues exactly one load per serializer slot of `maxWordOut` cycles, so the serializer is never reloaded mid-drain. Gives the upstream demapper a ready/valid handshake, rejects invalid modulation orders and exposes FIFO level for flow monitoring.

---
 rtl/p2s_feed_scheduler_if.sv | 29 ++
 rtl/p2s_feed_scheduler.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/p2s_feed_scheduler_if.sv
// Demapper-to-serializer handshake bundle: upstream word/order in, serializer load strobe and flow status out.
// The scheduler takes the slave side; the upstream/serializer environment takes the master side.
interface p2s_feed_scheduler_if #(
    parameter int maxWordOut = 6,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic                            flush;
    logic                            ival;
    logic                            iready;
    logic [3:0]                      modOrder;
    logic signed [5*maxWordOut-1:0]  ibit;
    logic                            oval;
    logic [3:0]                      oorder;
    logic signed [5*maxWordOut-1:0]  obit;
    logic [LW-1:0]                   level;
    logic                            errOrder;

    modport slave (
        input  flush, ival, modOrder, ibit,
        output iready, oval, oorder, obit, level, errOrder
    );

    modport master (
        output flush, ival, modOrder, ibit,
        input  iready, oval, oorder, obit, level, errOrder
    );
endinterface

// File: rtl/p2s_feed_scheduler.sv
// Buffers soft-bit words and issues one serializer load per maxWordOut-cycle slot; load one edge after a word is visible in IDLE.
// iready = !full, taken before any same-cycle pop; flush empties the FIFO but never shortens the running slot.
module p2s_feed_scheduler #(
    parameter int maxWordOut = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk_h,
    input  logic                    rst,
    p2s_feed_scheduler_if.slave     bus
);
    localparam int BW = 5 * maxWordOut;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = (maxWordOut > 1) ? $clog2(maxWordOut) : 1;

    localparam logic [3:0]    MAX_ORD    = 4'(maxWordOut);
    localparam logic [LW-1:0] FULL_LVL   = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(maxWordOut - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    typedef struct packed {
        logic [3:0]           ord;
        logic signed [BW-1:0] bits;
    } entry_t;

    entry_t         r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [LW-1:0]  r_level;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           r_oval;
    logic [3:0]     r_oorder;
    logic [BW-1:0]  r_obit;
    logic           r_err;

    logic w_full;
    logic w_empty;
    logic w_hs;
    logic w_ord_ok;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_level == FULL_LVL);
    assign w_empty  = (r_level == '0);
    assign w_hs     = bus.ival && !w_full && !bus.flush;
    assign w_ord_ok = (bus.modOrder != 4'd0) && (bus.modOrder <= MAX_ORD);
    assign w_push   = w_hs && w_ord_ok;

    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Emptiness comes from the registered level, so a word written this cycle cannot be popped until the next.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !bus.flush) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = CNT_RELOAD;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (!w_empty && !bus.flush) begin
                    w_pop     = 1'b1;
                    w_cnt_nxt = CNT_RELOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_h) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{ord: bus.modOrder, bits: bus.ibit};
        end
    end

    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_hs && !w_ord_ok;
            if (bus.flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
            end
        end
    end

    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            r_oval   <= 1'b0;
            r_oorder <= '0;
            r_obit   <= '0;
        end else begin
            r_oval <= w_pop;
            if (w_pop) begin
                r_oorder <= r_mem[r_rptr].ord;
                r_obit   <= r_mem[r_rptr].bits;
            end
        end
    end

    assign bus.iready   = !w_full;
    assign bus.oval     = r_oval;
    assign bus.oorder   = r_oorder;
    assign bus.obit     = r_obit;
    assign bus.level    = r_level;
    assign bus.errOrder = r_err;

endmodule
